// File: rtl/dmem_pkg.sv
// Shared FSM encoding and store byte-merge helper for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int CNT_BITS = 4;
  localparam int MERGE_W  = 128;
  localparam int MERGE_NB = MERGE_W / 8;

  // Callers zero-extend to MERGE_W and truncate the result back to their word width.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_NB-1:0] byte_en
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_NB; i++) begin
      if (byte_en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wait_state_data_memory_if.sv
// Load/store request and response bundle between the MEM stage (master) and the data memory (slave).
interface wait_state_data_memory_if #(
  parameter int DATA_BIT_WIDTH = 32
);
  localparam int NBYTES = DATA_BIT_WIDTH / 8;

  logic                      req;
  logic                      wrEn;
  logic [DATA_BIT_WIDTH-1:0] addr;
  logic [NBYTES-1:0]         byteEn;
  logic [DATA_BIT_WIDTH-1:0] dataIn;
  logic                      ready;
  logic                      rspValid;
  logic                      rspErr;
  logic [DATA_BIT_WIDTH-1:0] rdData;
  logic                      busy;

  modport master (
    output req, wrEn, addr, byteEn, dataIn,
    input  ready, rspValid, rspErr, rdData, busy
  );

  modport slave (
    input  req, wrEn, addr, byteEn, dataIn,
    output ready, rspValid, rspErr, rdData, busy
  );

endinterface

// File: rtl/Register.sv
// Generic enable-gated register with synchronous active-high clear; one-cycle latency, no backpressure.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/dmem_array.sv
// Single-port word array: write on posedge, combinational read; indices >= DEPTH read 0 and ignore writes.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = AW + 1;
  localparam logic [AW:0] DEPTH_C = AW1'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             hit;

  assign hit = ({1'b0, addr_i} < DEPTH_C);

  always_ff @(posedge clk_i) begin
    if (we_i && hit) begin
      mem[addr_i[ABITS-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = hit ? mem[addr_i[ABITS-1:0]] : '0;

endmodule

// File: rtl/wait_state_data_memory.sv
// Data memory with req/ready handshake, byte-lane stores and post-reset zero-fill; response WAIT_STATES+1
// cycles after accept; ready is low while clearing or while a transaction is in flight.
module wait_state_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2,
  parameter int DMEMWORDS      = 2048,
  parameter int WAIT_STATES    = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  wait_state_data_memory_if.slave bus
);

  localparam int NBYTES  = DATA_BIT_WIDTH / 8;
  localparam int IDXBITS = DMEMADDRBITS - DMEMWORDBITS;
  localparam int IDXW1   = IDXBITS + 1;

  localparam logic [IDXBITS-1:0]  LAST_IDX  = IDXBITS'(DMEMWORDS - 1);
  localparam logic [IDXBITS:0]    WORDS_C   = IDXW1'(DMEMWORDS);
  localparam logic [CNT_BITS-1:0] WAIT_INIT = CNT_BITS'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [IDXBITS-1:0]        clr_idx_q, clr_idx_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic [DATA_BIT_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                      accept;
  logic [IDXBITS-1:0]        idx_q;
  logic [DATA_BIT_WIDTH-1:0] wdata_q;
  logic [NBYTES:0]           ctrl_q;
  logic                      wr_q;
  logic [NBYTES-1:0]         be_q;
  logic                      in_range;

  logic                      mem_we;
  logic [IDXBITS-1:0]        mem_addr;
  logic [DATA_BIT_WIDTH-1:0] mem_wdata;
  logic [DATA_BIT_WIDTH-1:0] mem_rdata;
  logic [DATA_BIT_WIDTH-1:0] merged;
  logic [DATA_BIT_WIDTH-1:0] resp_word;

  logic                      unused_addr;

  assign unused_addr = ^{bus.addr[DATA_BIT_WIDTH-1:DMEMADDRBITS], bus.addr[DMEMWORDBITS-1:0]};

  assign accept = (state_q == IDLE) && bus.req;

  Register #(.WIDTH(IDXBITS)) u_idx_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     (bus.addr[DMEMADDRBITS-1:DMEMWORDBITS]),
    .q_o     (idx_q)
  );

  Register #(.WIDTH(DATA_BIT_WIDTH)) u_data_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     (bus.dataIn),
    .q_o     (wdata_q)
  );

  Register #(.WIDTH(NBYTES + 1)) u_ctrl_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     ({bus.wrEn, bus.byteEn}),
    .q_o     (ctrl_q)
  );

  assign wr_q     = ctrl_q[NBYTES];
  assign be_q     = ctrl_q[NBYTES-1:0];
  assign in_range = ({1'b0, idx_q} < WORDS_C);

  dmem_array #(
    .WIDTH (DATA_BIT_WIDTH),
    .DEPTH (DMEMWORDS),
    .AW    (IDXBITS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign merged = DATA_BIT_WIDTH'(merge(MERGE_W'(mem_rdata), MERGE_W'(wdata_q), MERGE_NB'(be_q)));

  // Out-of-range transactions answer with zero for both loads and dropped stores.
  always_comb begin
    resp_word = '0;
    if (in_range) begin
      resp_word = wr_q ? merged : mem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    mem_addr  = idx_q;
    mem_wdata = merged;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx_q;
        mem_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IDXBITS'(1);
        end
      end
      IDLE: begin
        if (bus.req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        mem_we    = wr_q && in_range;
        rd_data_d = resp_word;
        state_d   = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // A reset landing on the commit edge must abort the store.
    if (reset_i) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.rspValid = (state_q == RESP);
  assign bus.rspErr   = (state_q == RESP) && !in_range;
  assign bus.rdData   = (state_q == RESP) ? resp_word : rd_data_q;
  assign bus.busy     = (state_q == CLEAR);

endmodule
